// File: rtl/prng_mmio_responder_pkg.sv
// Shared definitions for the PRNG memory-mapped responder: register offsets,
// channel state encoding and the xorshift32 step function.
package prng_mmio_responder_pkg;

  // Default placement of the PRNG window in the SoC address map.
  localparam logic [31:0] PRNG_BASE_ADDRESS  = 32'h4000_0000;

  // Register offsets inside the two-word window.
  localparam logic [31:0] PRNG_SEED_OFFSET   = 32'h0000_0000;
  localparam logic [31:0] PRNG_RANDOM_OFFSET = 32'h0000_0004;

  // Per-channel handshake state: a request moves IDLE to RESPOND for one cycle.
  typedef enum logic {
    CH_IDLE    = 1'b0,
    CH_RESPOND = 1'b1
  } chan_state_e;

  // One xorshift32 step (13, 17, 5), every shift truncated to 32 bits.
  function automatic logic [31:0] xorshift32_step(input logic [31:0] x);
    logic [31:0] v;
    v = x;
    v = v ^ (v << 13);
    v = v ^ (v >> 17);
    v = v ^ (v << 5);
    return v;
  endfunction

endpackage

// File: rtl/prng_mmio_responder.sv
// Slave endpoint for the PRNG slot. Decodes the SEED/RANDOM window and
// answers each read or write request with a one-cycle registered done pulse,
// plus error flag and read data that are valid only during that pulse.
module prng_mmio_responder
  import prng_mmio_responder_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDRESS = ADDR_WIDTH'(PRNG_BASE_ADDRESS),
  parameter logic [31:0]           DEFAULT_SEED = 32'hDEAD_BEEF
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  write_i,
  input  logic [ADDR_WIDTH-1:0] write_address_i,
  input  logic [31:0]           write_data_i,
  input  logic [3:0]            write_strobe_i,
  output logic                  write_done_o,
  output logic                  write_error_o,
  input  logic                  read_i,
  input  logic [ADDR_WIDTH-1:0] read_address_i,
  output logic [31:0]           read_data_o,
  output logic                  read_done_o,
  output logic                  read_error_o
);

  localparam logic [ADDR_WIDTH-1:0] SEED_OFF   = ADDR_WIDTH'(PRNG_SEED_OFFSET);
  localparam logic [ADDR_WIDTH-1:0] RANDOM_OFF = ADDR_WIDTH'(PRNG_RANDOM_OFFSET);

  chan_state_e r_wr_state, w_wr_state_nxt;
  chan_state_e r_rd_state, w_rd_state_nxt;

  logic [31:0] r_state;
  logic [31:0] r_seed;
  logic        r_write_error;
  logic        r_read_error;
  logic [31:0] r_read_data;

  logic [ADDR_WIDTH-1:0] w_wr_offset;
  logic [ADDR_WIDTH-1:0] w_rd_offset;
  logic                  w_wr_seed_ok;
  logic                  w_rd_random;
  logic [31:0]           w_next_state;
  logic [31:0]           w_rd_data_d;
  logic                  w_rd_error_d;

  // Offsets relative to the window; addresses below the base wrap to a large
  // offset and therefore decode as errors, as do misaligned addresses.
  assign w_wr_offset  = write_address_i - BASE_ADDRESS;
  assign w_rd_offset  = read_address_i - BASE_ADDRESS;
  assign w_next_state = xorshift32_step(r_state);

  // Only a full-word, non-zero write to SEED is accepted; zero would lock the generator.
  assign w_wr_seed_ok = write_i && (w_wr_offset == SEED_OFF) &&
                        (write_strobe_i == 4'hF) && (write_data_i != 32'h0000_0000);
  assign w_rd_random  = read_i && (w_rd_offset == RANDOM_OFF);

  // Read response decode: SEED returns the pre-write seed, RANDOM the next state.
  always_comb begin
    w_rd_data_d  = 32'h0000_0000;
    w_rd_error_d = 1'b0;
    if (read_i) begin
      if (w_rd_offset == SEED_OFF) begin
        w_rd_data_d = r_seed;
      end else if (w_rd_offset == RANDOM_OFF) begin
        w_rd_data_d = w_next_state;
      end else begin
        w_rd_error_d = 1'b1;
      end
    end else begin
      w_rd_data_d  = 32'h0000_0000;
      w_rd_error_d = 1'b0;
    end
  end

  // Channel next-state: any request enters RESPOND, including one arriving in RESPOND.
  always_comb begin
    w_wr_state_nxt = CH_IDLE;
    w_rd_state_nxt = CH_IDLE;
    case (r_wr_state)
      CH_IDLE:    w_wr_state_nxt = write_i ? CH_RESPOND : CH_IDLE;
      CH_RESPOND: w_wr_state_nxt = write_i ? CH_RESPOND : CH_IDLE;
      default:    w_wr_state_nxt = CH_IDLE;
    endcase
    case (r_rd_state)
      CH_IDLE:    w_rd_state_nxt = read_i ? CH_RESPOND : CH_IDLE;
      CH_RESPOND: w_rd_state_nxt = read_i ? CH_RESPOND : CH_IDLE;
      default:    w_rd_state_nxt = CH_IDLE;
    endcase
  end

  // Channel state registers; reset drops any pending done pulse.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wr_state <= CH_IDLE;
      r_rd_state <= CH_IDLE;
    end else begin
      r_wr_state <= w_wr_state_nxt;
      r_rd_state <= w_rd_state_nxt;
    end
  end

  // Generator state and seed; a valid seed write takes priority over a RANDOM read.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= DEFAULT_SEED;
      r_seed  <= DEFAULT_SEED;
    end else if (w_wr_seed_ok) begin
      r_state <= write_data_i;
      r_seed  <= write_data_i;
    end else if (w_rd_random) begin
      r_state <= w_next_state;
    end
  end

  // Response flags and data, captured with the request and zero otherwise.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_write_error <= 1'b0;
      r_read_error  <= 1'b0;
      r_read_data   <= 32'h0000_0000;
    end else begin
      r_write_error <= write_i && !w_wr_seed_ok;
      r_read_error  <= w_rd_error_d;
      r_read_data   <= w_rd_data_d;
    end
  end

  assign write_done_o  = (r_wr_state == CH_RESPOND);
  assign write_error_o = r_write_error;
  assign read_done_o   = (r_rd_state == CH_RESPOND);
  assign read_error_o  = r_read_error;
  assign read_data_o   = r_read_data;

endmodule
